// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: operand sequencer for the fp16 MAC stage.
// Buffers up to DEPTH A/B operand pairs, streams them one per cycle with
// an enable qualifier, waits DRAIN_CYCLES for the MAC to settle, then
// pulses done. Optional zero-operand skipping is enabled by defining
// MAC_FEED_ZERO_SKIP_EN, which also adds the skip_cnt output.
module mac_operand_feeder #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    output logic              busy,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [15:0]       op_a,
    output logic [15:0]       op_b,
    output logic [ADDR_W-1:0] pair_idx,
    output logic              done,
    output logic              len_err
`ifdef MAC_FEED_ZERO_SKIP_EN
    ,output logic [ADDR_W:0]  skip_cnt
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE = DRAIN_W'(1);
    localparam logic [ADDR_W:0]    LEN_MAX   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]    LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0]  IDX_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  idx, idx_nxt;
    logic [ADDR_W:0]    run_len, run_len_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic               len_bad;
    logic               last_pair;
    logic               len_err_nxt;

    logic [15:0] mem_a [DEPTH];
    logic [15:0] mem_b [DEPTH];
    logic        wr_ok;

    logic              stream_nxt;
    logic              present_nxt;
    logic [15:0]       a_rd, b_rd;
    logic              busy_nxt, mac_clr_nxt, mac_en_nxt, done_nxt;
    logic [15:0]       op_a_nxt, op_b_nxt;
    logic [ADDR_W-1:0] pair_idx_nxt;
`ifdef MAC_FEED_ZERO_SKIP_EN
    logic              zero_nxt;
    logic [ADDR_W:0]   skip_cnt_nxt;
`endif

    // Operand buffers: writable only while no run is in flight.
    assign wr_ok = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk) begin
        // buffer write port, no reset on storage
        if (wr_en && wr_ok) begin
            if (wr_sel) begin
                mem_b[wr_addr] <= wr_data;
            end else begin
                mem_a[wr_addr] <= wr_data;
            end
        end
    end

    // State register with run length, pair index and drain counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            run_len   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            run_len   <= run_len_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    assign len_bad   = (len == '0) || (len > LEN_MAX);
    assign last_pair = ({1'b0, idx} == (run_len - LEN_ONE));

    // Next-state logic: sequencing of clear, stream, drain and done.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        run_len_nxt = run_len;
        drain_nxt   = drain_cnt;
        len_err_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_bad) begin
                        state_nxt   = S_DONE;
                        len_err_nxt = 1'b1;
                    end else begin
                        state_nxt   = S_CLEAR;
                        run_len_nxt = len;
                    end
                end
            end
            S_CLEAR: begin
                state_nxt = S_STREAM;
                idx_nxt   = '0;
            end
            S_STREAM: begin
                if (last_pair) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end
                end else begin
                    idx_nxt = idx + IDX_ONE;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    drain_nxt = drain_cnt - DRAIN_ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: outputs are computed from the upcoming state and
    // index so that the registered outputs line up with that state.
    always_comb begin
        stream_nxt   = (state_nxt == S_STREAM);
        a_rd         = mem_a[idx_nxt];
        b_rd         = mem_b[idx_nxt];
`ifdef MAC_FEED_ZERO_SKIP_EN
        zero_nxt     = (a_rd[14:0] == '0) || (b_rd[14:0] == '0);
        present_nxt  = stream_nxt && !zero_nxt;
        skip_cnt_nxt = skip_cnt;
        if (state_nxt == S_CLEAR) begin
            skip_cnt_nxt = '0;
        end else if (stream_nxt && zero_nxt) begin
            skip_cnt_nxt = skip_cnt + LEN_ONE;
        end
`else
        present_nxt  = stream_nxt;
`endif
        mac_en_nxt   = present_nxt;
        op_a_nxt     = present_nxt ? a_rd : '0;
        op_b_nxt     = present_nxt ? b_rd : '0;
        pair_idx_nxt = stream_nxt ? idx_nxt : pair_idx;
        mac_clr_nxt  = (state_nxt == S_CLEAR);
        busy_nxt     = (state_nxt == S_CLEAR) || (state_nxt == S_STREAM) ||
                       (state_nxt == S_DRAIN);
        done_nxt     = (state_nxt == S_DONE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            pair_idx <= '0;
            done     <= 1'b0;
            len_err  <= 1'b0;
`ifdef MAC_FEED_ZERO_SKIP_EN
            skip_cnt <= '0;
`endif
        end else begin
            busy     <= busy_nxt;
            mac_clr  <= mac_clr_nxt;
            mac_en   <= mac_en_nxt;
            op_a     <= op_a_nxt;
            op_b     <= op_b_nxt;
            pair_idx <= pair_idx_nxt;
            done     <= done_nxt;
            len_err  <= len_err_nxt;
`ifdef MAC_FEED_ZERO_SKIP_EN
            skip_cnt <= skip_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed testbench for mac_operand_feeder (DEPTH=8, DRAIN_CYCLES=2).
module tb_mac_operand_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        wr_sel;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  len;
    logic        start;
    logic        busy, mac_clr, mac_en, done, len_err;
    logic [15:0] op_a, op_b;
    logic [2:0]  pair_idx;
`ifdef MAC_FEED_ZERO_SKIP_EN
    logic [3:0]  skip_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] ma [8];
    logic [15:0] mb [8];

    mac_operand_feeder #(
        .DEPTH(8),
        .ADDR_W(3),
        .DRAIN_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .len(len),
        .start(start),
        .busy(busy),
        .mac_clr(mac_clr),
        .mac_en(mac_en),
        .op_a(op_a),
        .op_b(op_b),
        .pair_idx(pair_idx),
        .done(done),
`ifdef MAC_FEED_ZERO_SKIP_EN
        .skip_cnt(skip_cnt),
`endif
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge; write lands on the next rising edge.
    task automatic wr(input logic sel, input int addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = data;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Issue start with length L and check every cycle until back in IDLE.
    task automatic do_run(input int L);
        bit          bad;
        int          kmax;
        bit          e_str, e_zero, e_en;
        logic [4:0]  e_ctl;
        logic [15:0] e_a, e_b;
        int          i;
        bad  = (L == 0) || (L > 8);
        kmax = bad ? 2 : L + 5;
        start = 1'b1;
        len   = 4'(L);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            if (bad) begin
                e_ctl = {1'b0, 1'b0, 1'b0, k == 1, k == 1};
                e_a   = '0;
                e_b   = '0;
                e_str = 1'b0;
                i     = 0;
            end else begin
                e_str = (k >= 2) && (k <= L + 1);
                i     = e_str ? k - 2 : 0;
`ifdef MAC_FEED_ZERO_SKIP_EN
                e_zero = (ma[i][14:0] == 15'd0) || (mb[i][14:0] == 15'd0);
`else
                e_zero = 1'b0;
`endif
                e_en  = e_str && !e_zero;
                e_a   = e_en ? ma[i] : 16'h0000;
                e_b   = e_en ? mb[i] : 16'h0000;
                // {busy, mac_clr, mac_en, done, len_err}
                e_ctl = {(k >= 1) && (k <= L + 3), k == 1, e_en, k == L + 4, 1'b0};
            end
            chk($sformatf("ctl L=%0d k=%0d", L, k), 32'({busy, mac_clr, mac_en, done, len_err}), 32'(e_ctl));
            chk($sformatf("op_a L=%0d k=%0d", L, k), 32'(op_a), 32'(e_a));
            chk($sformatf("op_b L=%0d k=%0d", L, k), 32'(op_b), 32'(e_b));
            if (e_str) chk($sformatf("pair_idx L=%0d k=%0d", L, k), 32'(pair_idx), 32'(i));
            @(negedge clk);
        end
    endtask

    initial begin
        int n_done, n_en;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        start   = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ctl", 32'({busy, mac_clr, mac_en, done, len_err}), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_op_b", 32'(op_b), 32'd0);
        chk("rst_pair_idx", 32'(pair_idx), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic run, len=4, done at t0+8
        wr(1'b0, 0, 16'h3C00);
        wr(1'b0, 1, 16'h4000);
        wr(1'b0, 2, 16'h4200);
        wr(1'b0, 3, 16'h3C00);
        for (int j = 0; j < 4; j++) wr(1'b1, j, 16'h4000);
        do_run(4);

        // +/-0.0 operands: streamed by default, skipped when the feature is on
        wr(1'b0, 1, 16'h8000);
        wr(1'b0, 2, 16'h0000);
        do_run(4);
`ifdef MAC_FEED_ZERO_SKIP_EN
        chk("skip_cnt", 32'(skip_cnt), 32'd2);
`endif

        // full depth, len=8, done at t0+12
        for (int j = 0; j < 8; j++) begin
            wr(1'b0, j, 16'h3800 + 16'(j * 17));
            wr(1'b1, j, 16'h4400 + 16'(j));
        end
        do_run(8);

        // invalid lengths
        do_run(0);
        do_run(9);

        // write and second start during STREAM are ignored
        start = 1'b1;
        len   = 4'd4;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        n_en   = 0;
        for (int k = 1; k <= 12; k++) begin
            n_done += int'(done);
            n_en   += int'(mac_en);
            if (k == 2) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 3'd1;
                wr_data = 16'h7C00;
                start   = 1'b1;
                len     = 4'd4;
            end else if (k == 3) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("prot_done_count", 32'(n_done), 32'd1);
        chk("prot_en_count", 32'(n_en), 32'd4);
        do_run(2);

        // reset in the second STREAM cycle
        start = 1'b1;
        len   = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_en", 32'(mac_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ctl", 32'({busy, mac_clr, mac_en, done, len_err}), 32'd0);
        chk("midrst_op_a", 32'(op_a), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            n_done += int'(done);
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(n_done), 32'd0);
        do_run(2);

        // single pair
        do_run(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
